regfile_mp: RTL and testbench

Parametrised multi-port register file for the CPU datapath, replacing the fixed 32×32, two-read/one-write register file. It adds:
- configurable width, depth and port counts;
- a hardwired zero register;
- prioritised multi-port writes;
- a per-register busy scoreboard so multi-cycle producers (load, multiply) can reserve a destination and the decode stage can stall on it.

It sits between decode (reads, claims) and writeback (writes).

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_scoreboard.sv | 72 +++++++
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file:
//   - default register width and address width
//   - ZERO_REG, the hardwired-zero register index
//   - last_hit(): picks the highest-indexed asserted port from a hit vector,
//     which is how same-address write conflicts are resolved
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  // Upper bound on write ports handled by last_hit(); NUM_WR must not exceed it.
  localparam int MAX_PORTS  = 16;

  // Returns the highest set bit position of hits, or -1 when none is set.
  function automatic int last_hit(input logic [MAX_PORTS-1:0] hits);
    int idx;
    idx = -1;
    for (int p = 0; p < MAX_PORTS; p++) begin
      if (hits[p]) idx = p;
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per register plus a registered popcount of those bits.
// A write clears the target's bit, a claim sets it; when both hit the same
// register in one cycle the claim wins (newer producer supersedes the old).
// Register 0 is never busy.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   we, wa         write-port enables / packed addresses (busy-clear sources)
//   claim_valid    reserve claim_addr for a pending producer
//   claim_addr     register to reserve
//   busy           busy vector, one bit per register
//   busy_count     number of busy registers, updated with the busy bits
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic                     claim_valid,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [2**ADDR_W-1:0]     busy,
  output logic [ADDR_W:0]          busy_count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic [ADDR_W:0]  r_count;
  logic [ADDR_W:0]  w_count_next;

  // Clears first, then the claim, so a claim overrides a same-cycle write.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default before any conditional logic, so no latch can be inferred.
  always_comb begin
    w_busy_next = r_busy;
    for (int p = 0; p < NUM_WR; p++) begin
      if (we[p]) w_busy_next[wa[p*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (claim_valid) w_busy_next[claim_addr] = 1'b1;
    w_busy_next[ZERO_REG] = 1'b0;

    // Count the next-state bits so busy_count lands on the same edge.
    w_count_next = '0;
    for (int a = 0; a < DEPTH; a++) begin
      w_count_next = w_count_next + {{ADDR_W{1'b0}}, w_busy_next[a]};
    end
  end

  // NOTE: sequential state is updated with non-blocking '<=' so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_next;
      r_count <= w_count_next;
    end
  end

  assign busy       = r_busy;
  assign busy_count = r_count;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with hardwired-zero register 0,
// prioritised multi-port writes (highest-indexed port wins on a conflict)
// and a per-register busy scoreboard for multi-cycle producers.
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to
// matching read ports (and mask their busy flag unless a claim also targets
// that register). Without it, reads see array contents only.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   rd_addr        NUM_RD packed read addresses
//   rd_data        NUM_RD packed read data (combinational)
//   rd_busy        busy flag of each read address
//   we, wa, wd     NUM_WR write enables / packed addresses / packed data
//   claim_valid    reserve claim_addr for a pending producer
//   claim_addr     register to reserve
//   busy_count     number of registers currently reserved
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic                     claim_valid,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [ADDR_W:0]          busy_count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic [DEPTH-1:0]  w_wr_en;
  logic [DATA_W-1:0] w_wr_data [DEPTH];

  // Per-register write select: the highest-indexed port targeting it wins.
  always_comb begin
    logic [MAX_PORTS-1:0] v_hits;
    int                   v_idx;
    for (int a = 0; a < DEPTH; a++) begin
      w_wr_en[a]   = 1'b0;
      w_wr_data[a] = '0;
      v_hits       = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        v_hits[p] = we[p] && (wa[p*ADDR_W +: ADDR_W] == ADDR_W'(a));
      end
      v_idx = last_hit(v_hits);
      for (int p = 0; p < NUM_WR; p++) begin
        if (p == v_idx) begin
          w_wr_en[a]   = 1'b1;
          w_wr_data[a] = wd[p*DATA_W +: DATA_W];
        end
      end
    end
    w_wr_en[ZERO_REG] = 1'b0;
  end

  // NOTE: the array is built from flops, not a RAM macro, so it takes the
  // asynchronous reset; a reset mid-operation must leave nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) r_mem[a] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (w_wr_en[a]) r_mem[a] <= w_wr_data[a];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .wa          (wa),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .busy        (w_busy),
    .busy_count  (busy_count)
  );

  always_comb begin
    logic [ADDR_W-1:0] v_addr;
`ifdef REGFILE_BYPASS_EN
    logic [MAX_PORTS-1:0] v_hits;
    int                   v_idx;
`endif
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      v_addr = rd_addr[i*ADDR_W +: ADDR_W];
      if (v_addr != ADDR_W'(ZERO_REG)) begin
        rd_data[i*DATA_W +: DATA_W] = r_mem[v_addr];
        rd_busy[i]                  = w_busy[v_addr];
`ifdef REGFILE_BYPASS_EN
        v_hits = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          v_hits[p] = we[p] && (wa[p*ADDR_W +: ADDR_W] == v_addr);
        end
        v_idx = last_hit(v_hits);
        for (int p = 0; p < NUM_WR; p++) begin
          if (p == v_idx) begin
            rd_data[i*DATA_W +: DATA_W] = wd[p*DATA_W +: DATA_W];
            // The forwarded write retires the old producer; only a
            // same-cycle claim keeps the register reserved.
            rd_busy[i] = w_busy[v_addr] && claim_valid && (claim_addr == v_addr);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp (default parameters). Directed scenarios
// followed by a randomized run against a behavioural array/busy-set model.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wa;
  logic [NW*DW-1:0]  wd;
  logic              claim_valid;
  logic [AW-1:0]     claim_addr;
  logic [AW:0]       busy_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .busy_count  (busy_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      m_mem[a]  = '0;
      m_busy[a] = 1'b0;
    end
  endfunction

  // Writes applied in port order so the later port overwrites; claims last.
  function automatic void model_edge();
    int a;
    for (int p = 0; p < NW; p++) begin
      a = int'(wa[p*AW +: AW]);
      if (we[p] && a != 0) begin
        m_mem[a]  = wd[p*DW +: DW];
        m_busy[a] = 1'b0;
      end
    end
    if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1'b1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int a = 0; a < DEPTH; a++) n += int'(m_busy[a]);
    return n;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int i);
    int a;
    logic [DW-1:0] d;
    a = int'(rd_addr[i*AW +: AW]);
    if (a == 0) return '0;
    d = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++)
      if (we[p] && int'(wa[p*AW +: AW]) == a) d = wd[p*DW +: DW];
`endif
    return d;
  endfunction

  function automatic logic exp_busy(input int i);
    int a;
    logic b;
    a = int'(rd_addr[i*AW +: AW]);
    if (a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NW; p++)
      if (we[p] && int'(wa[p*AW +: AW]) == a)
        b = m_busy[a] && claim_valid && (int'(claim_addr) == a);
`endif
    return b;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle();
    we = '0; wa = '0; wd = '0; claim_valid = 1'b0; claim_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle();
    rd_addr = {5'd6, 5'd5};
    model_reset();
    @(negedge clk);
    n_checks++;
    if (rd_data !== '0 || rd_busy !== '0 || busy_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rd_data=%h rd_busy=%b busy_count=%0d expected 0/0/0",
               rd_data, rd_busy, busy_count);
    end
    // Writes and claims must be ignored while held in reset.
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'h1234_5678};
    claim_valid = 1'b1; claim_addr = 5'd6;
    step();
    n_checks++;
    if (rd_data !== '0 || rd_busy !== '0 || busy_count !== '0) begin
      n_fail++;
      $display("FAIL reset_ignores_ops: rd_data=%h rd_busy=%b busy_count=%0d expected 0/0/0",
               rd_data, rd_busy, busy_count);
    end
    idle();
    rst = 1'b1;
    // Write 0xDEADBEEF to r5 and claim r6 on the first edge out of reset.
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEAD_BEEF};
    claim_valid = 1'b1; claim_addr = 5'd6;
    step();
    idle();
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_busy[1] !== 1'b1 || busy_count !== 6'd1) begin
      n_fail++;
      $display("FAIL first_edge_after_reset: r5=%h busy6=%b count=%0d expected deadbeef/1/1",
               rd_data[31:0], rd_busy[1], busy_count);
    end
    // Asynchronous pulse in the middle of the low phase.
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h0 || rd_busy !== '0 || busy_count !== 6'd0) begin
      n_fail++;
      $display("FAIL async_reset: r5=%h rd_busy=%b count=%0d expected 0/00/0",
               rd_data[31:0], rd_busy, busy_count);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_zero_reg();
    idle();
    rd_addr = {5'd0, 5'd0};
    we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'hFFFF_FFFF, 32'h1234_5678};
    claim_valid = 1'b1; claim_addr = 5'd0;
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      n_fail++;
      $display("FAIL zero_same_cycle: rd_data=%h rd_busy=%b expected 0/00", rd_data, rd_busy);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_busy !== '0 || busy_count !== 6'd0) begin
      n_fail++;
      $display("FAIL zero_reg: rd_data=%h rd_busy=%b count=%0d expected 0/00/0",
               rd_data, rd_busy, busy_count);
    end
  endtask

  task automatic test_write_conflict();
    idle();
    rd_addr = {5'd0, 5'd7};
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h5555_5555, 32'hAAAA_AAAA};
    step();
    idle();
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h5555_5555) begin
      n_fail++;
      $display("FAIL write_conflict: r7=%h expected 55555555", rd_data[31:0]);
    end
    // Distinct addresses on both ports in one cycle both land.
    we = 2'b11; wa = {5'd11, 5'd10}; wd = {32'h0000_0B0B, 32'h0000_0A0A};
    step();
    idle();
    rd_addr = {5'd11, 5'd10};
    #1;
    n_checks++;
    if (rd_data !== {32'h0000_0B0B, 32'h0000_0A0A}) begin
      n_fail++;
      $display("FAIL dual_write: got %h expected 00000b0b00000a0a", rd_data);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rd_addr = {5'd4, 5'd3};
    claim_valid = 1'b1; claim_addr = 5'd3;
    step();
    idle();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || busy_count !== 6'd1) begin
      n_fail++;
      $display("FAIL claim_r3: busy=%b count=%0d expected 1/1", rd_busy[0], busy_count);
    end
    we = 2'b10; wa = {5'd3, 5'd0}; wd = {32'h42, 32'h0};
    step();
    idle();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0 || busy_count !== 6'd0 || rd_data[31:0] !== 32'h42) begin
      n_fail++;
      $display("FAIL write_clears_r3: busy=%b count=%0d data=%h expected 0/0/42",
               rd_busy[0], busy_count, rd_data[31:0]);
    end
    we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'h0, 32'h77};
    claim_valid = 1'b1; claim_addr = 5'd4;
    step();
    idle();
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1 || busy_count !== 6'd1 || rd_data[63:32] !== 32'h77) begin
      n_fail++;
      $display("FAIL claim_beats_write_r4: busy=%b count=%0d data=%h expected 1/1/77",
               rd_busy[1], busy_count, rd_data[63:32]);
    end
    // Re-claiming a busy register keeps it busy and does not double count.
    claim_valid = 1'b1; claim_addr = 5'd4;
    step();
    idle();
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1 || busy_count !== 6'd1) begin
      n_fail++;
      $display("FAIL reclaim_r4: busy=%b count=%0d expected 1/1", rd_busy[1], busy_count);
    end
    we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'h0, 32'h78};
    step();
    idle();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_now;
`ifdef REGFILE_BYPASS_EN
    exp_now = 32'hCAFE;
`else
    exp_now = 32'h0;
`endif
    idle();
    rd_addr = {5'd0, 5'd9};
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'hCAFE};
    #1;
    n_checks++;
    if (rd_data[31:0] !== exp_now) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: r9=%h expected %h", rd_data[31:0], exp_now);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL bypass_next_cycle: r9=%h expected 0000cafe", rd_data[31:0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      if (it == 200) begin
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (busy_count !== 6'd0 || rd_busy !== '0) begin
          n_fail++;
          $display("FAIL rand_mid_reset: count=%0d rd_busy=%b expected 0/00", busy_count, rd_busy);
        end
        rst = 1'b1;
      end
      // Mostly low addresses so conflicts, claims and reads collide often.
      for (int i = 0; i < NR; i++)
        rd_addr[i*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                               : $urandom_range(0, 7));
      for (int p = 0; p < NW; p++) begin
        we[p]          = ($urandom_range(0, 2) != 0);
        wa[p*AW +: AW] = AW'($urandom_range(0, 7));
        wd[p*DW +: DW] = $urandom;
      end
      claim_valid = ($urandom_range(0, 2) == 0);
      claim_addr  = AW'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < NR; i++) begin
        n_checks++;
        if (rd_data[i*DW +: DW] !== exp_data(i) || rd_busy[i] !== exp_busy(i)) begin
          n_fail++;
          $display("FAIL rand_read it=%0d port=%0d addr=%0d: data=%h busy=%b expected %h/%b",
                   it, i, rd_addr[i*AW +: AW], rd_data[i*DW +: DW], rd_busy[i],
                   exp_data(i), exp_busy(i));
        end
      end
      n_checks++;
      if (int'(busy_count) != m_count()) begin
        n_fail++;
        $display("FAIL rand_busy_count it=%0d: got %0d expected %0d", it, busy_count, m_count());
      end
      step();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_write_conflict();
    test_scoreboard();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
